// File: rtl/if_axi_rd_if.sv
// Bundle of fetch-side request/response and AXI read-channel signals for if_axi_rd.
// The master modport is the bridge's view; the slave modport is the fetch stage plus memory side.
interface if_axi_rd_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  logic              if_valid;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [1:0]        if_size;
  logic              if_ready;
  logic [DATA_W-1:0] if_data_read;
  logic [1:0]        if_resp;

  logic              ar_valid;
  logic              ar_ready;
  logic [ADDR_W-1:0] ar_addr;
  logic [3:0]        ar_id;
  logic [7:0]        ar_len;
  logic [2:0]        ar_size;
  logic [1:0]        ar_burst;
  logic [2:0]        ar_prot;

  logic              r_valid;
  logic              r_ready;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;
  logic              r_last;
  logic [3:0]        r_id;

  modport master (
    input  if_valid, if_req, if_addr, if_size,
    output if_ready, if_data_read, if_resp,
    output ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst, ar_prot,
    input  ar_ready,
    input  r_valid, r_data, r_resp, r_last, r_id,
    output r_ready
  );

  modport slave (
    output if_valid, if_req, if_addr, if_size,
    input  if_ready, if_data_read, if_resp,
    input  ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst, ar_prot,
    output ar_ready,
    output r_valid, r_data, r_resp, r_last, r_id,
    input  r_ready
  );
endinterface

// File: rtl/if_axi_rd.sv
// Instruction-fetch to AXI read bridge: one single-beat read at a time, IDLE -> AR -> R -> DONE.
// All outputs come from registers; the 32-bit word selected by address bit 2 lands in if_data_read[31:0].
module if_axi_rd #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64,
  parameter logic [3:0]  AXI_ID = 4'h0
) (
  input  logic        clk,
  input  logic        rst,
  if_axi_rd_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              ar_valid_q;
  logic              r_ready_q;
  logic              if_ready_q;
  logic [DATA_W-1:0] data_q;
  logic [1:0]        resp_q;
  logic [31:0]       word_d;

  // r_last and r_id never influence completion; the first beat ends the fetch.
  logic unused_rsig;
  assign unused_rsig = ^{bus.r_last, bus.r_id};

  always_comb begin
    word_d = bus.r_data[31:0];
    if (addr_q[2]) word_d = bus.r_data[63:32];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      size_q     <= '0;
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
      if_ready_q <= 1'b0;
      data_q     <= '0;
      resp_q     <= '0;
    end else begin
      if_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.if_valid && !bus.if_req) begin
            addr_q     <= bus.if_addr;
            size_q     <= bus.if_size;
            ar_valid_q <= 1'b1;
            state_q    <= AR;
          end
        end
        AR: begin
          if (bus.ar_ready) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            state_q    <= R;
          end
        end
        R: begin
          if (bus.r_valid) begin
            r_ready_q  <= 1'b0;
            data_q     <= {{(DATA_W-32){1'b0}}, word_d};
            resp_q     <= bus.r_resp;
            if_ready_q <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ar_valid     = ar_valid_q;
  assign bus.ar_addr      = addr_q;
  assign bus.ar_size      = {1'b0, size_q};
  assign bus.ar_len       = 8'h00;
  assign bus.ar_burst     = 2'b01;
  assign bus.ar_prot      = 3'b100;
  assign bus.ar_id        = AXI_ID;
  assign bus.r_ready      = r_ready_q;
  assign bus.if_ready     = if_ready_q;
  assign bus.if_data_read = data_q;
  assign bus.if_resp      = resp_q;

endmodule

// File: tb/tb_if_axi_rd.sv
// Self-checking bench for if_axi_rd: expected fetch results are queued at request time
// and compared, with latency, when if_ready pulses.
module tb_if_axi_rd;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam logic [3:0]  ID = 4'hA;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  if_axi_rd_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  if_axi_rd #(.ADDR_W(AW), .DATA_W(DW), .AXI_ID(ID)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
    int          start;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks    = 0;
  int   failures  = 0;
  int   cyc       = 0;
  int   pulses    = 0;
  int   n_reads   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [85:0] cur_ar();
    return {bus.ar_valid, bus.r_ready, bus.ar_addr, bus.ar_size, bus.ar_len,
            bus.ar_burst, bus.ar_prot, bus.ar_id};
  endfunction

  // Scoreboard consumer: every if_ready pulse must match the oldest queued fetch.
  always @(negedge clk) begin
    if (bus.if_ready) begin
      pulses++;
      check_eq("ready_expected", 128'(sb.size() != 0), 128'(1));
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check_eq("if_data_read", 128'(bus.if_data_read), 128'(mon_e.data));
        check_eq("if_resp", 128'(bus.if_resp), 128'(mon_e.resp));
        check_eq("latency", 128'(cyc - mon_e.start), 128'(mon_e.lat));
      end
    end
  end

  // Called at a negedge, returns at a negedge with the bridge back in IDLE.
  task automatic do_read(input logic [63:0] addr, input logic [1:0] size, input int ar_dly,
                         input int r_dly, input logic [63:0] rdata, input logic [1:0] rresp);
    exp_t        e;
    logic [85:0] arv;
    bus.if_valid = 1'b1;
    bus.if_req   = 1'b0;
    bus.if_addr  = addr;
    bus.if_size  = size;
    e.data  = addr[2] ? {32'h0, rdata[63:32]} : {32'h0, rdata[31:0]};
    e.resp  = rresp;
    e.start = cyc;
    e.lat   = 3 + ar_dly + r_dly;
    sb.push_back(e);
    n_reads++;
    @(negedge clk);
    bus.if_valid = 1'b0;
    bus.if_addr  = ~addr;
    bus.if_size  = ~size;
    arv = {1'b1, 1'b0, addr, {1'b0, size}, 8'h00, 2'b01, 3'b100, ID};
    for (int i = 0; i < ar_dly; i++) begin
      check_eq("ar_hold", 128'(cur_ar()), 128'(arv));
      @(negedge clk);
    end
    check_eq("ar_issue", 128'(cur_ar()), 128'(arv));
    bus.ar_ready = 1'b1;
    @(negedge clk);
    bus.ar_ready = 1'b0;
    for (int i = 0; i < r_dly; i++) begin
      check_eq("r_wait", 128'({bus.ar_valid, bus.r_ready}), 128'(2'b01));
      @(negedge clk);
    end
    check_eq("r_phase", 128'({bus.ar_valid, bus.r_ready}), 128'(2'b01));
    bus.r_valid = 1'b1;
    bus.r_data  = rdata;
    bus.r_resp  = rresp;
    bus.r_last  = 1'b0;
    bus.r_id    = ~ID;
    @(negedge clk);
    bus.r_valid = 1'b0;
    bus.r_data  = {$urandom, $urandom};
    bus.r_resp  = 2'(~rresp);
    check_eq("ready_pulse", 128'(bus.if_ready), 128'(1));
    check_eq("done_idle_bus", 128'({bus.ar_valid, bus.r_ready}), 128'(2'b00));
    @(negedge clk);
    check_eq("ready_single", 128'(bus.if_ready), 128'(0));
    check_eq("hold_data", 128'(bus.if_data_read), 128'(e.data));
    check_eq("hold_resp", 128'(bus.if_resp), 128'(e.resp));
  endtask

  initial begin
    bus.if_valid = 1'b0;
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.if_size  = '0;
    bus.ar_ready = 1'b0;
    bus.r_valid  = 1'b0;
    bus.r_data   = '0;
    bus.r_resp   = '0;
    bus.r_last   = 1'b0;
    bus.r_id     = '0;

    repeat (3) @(negedge clk);
    check_eq("reset_ctrl", 128'({bus.ar_valid, bus.r_ready, bus.if_ready}), 128'(3'b000));
    check_eq("reset_data", 128'({bus.if_data_read, bus.if_resp}), 128'(0));
    check_eq("reset_latch", 128'({bus.ar_addr, bus.ar_size}), 128'(0));
    rst = 1'b1;
    @(negedge clk);

    do_read(64'h8000_0000, 2'b10, 0, 0, 64'h1122_3344_AABB_CCDD, 2'b00);
    do_read(64'h8000_0004, 2'b10, 0, 0, 64'h1122_3344_AABB_CCDD, 2'b00);
    do_read(64'h8000_0100, 2'b10, 3, 4, 64'hDEAD_BEEF_0BAD_F00D, 2'b00);
    do_read(64'h8000_0008, 2'b10, 1, 0, 64'h0123_4567_89AB_CDEF, 2'b10);
    do_read(64'h0000_1234_5678_9ABC, 2'b01, 0, 2, {$urandom, $urandom}, 2'b11);

    repeat (3) @(negedge clk);
    check_eq("idle_hold_resp", 128'(bus.if_resp), 128'(2'b11));

    // Reset while waiting for the R beat abandons the fetch.
    bus.if_valid = 1'b1;
    bus.if_addr  = 64'h8000_0010;
    bus.if_size  = 2'b10;
    @(negedge clk);
    bus.if_valid = 1'b0;
    bus.ar_ready = 1'b1;
    @(negedge clk);
    bus.ar_ready = 1'b0;
    check_eq("rst_test_in_r", 128'({bus.ar_valid, bus.r_ready}), 128'(2'b01));
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_eq("rst_mid_ctrl", 128'({bus.ar_valid, bus.r_ready, bus.if_ready}), 128'(3'b000));
    check_eq("rst_mid_data", 128'({bus.if_data_read, bus.if_resp}), 128'(0));
    check_eq("rst_mid_latch", 128'({bus.ar_addr, bus.ar_size}), 128'(0));
    bus.r_valid = 1'b1;
    bus.r_data  = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.r_resp  = 2'b00;
    @(negedge clk);
    bus.r_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("rst_no_ready", 128'({bus.if_ready, bus.ar_valid, bus.r_ready}), 128'(3'b000));
      @(negedge clk);
    end
    do_read(64'h8000_0014, 2'b10, 0, 0, 64'hCAFE_F00D_5555_AAAA, 2'b00);

    // Write requests are never accepted.
    bus.if_valid = 1'b1;
    bus.if_req   = 1'b1;
    bus.if_addr  = 64'h8000_0020;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("wr_no_ar", 128'({bus.ar_valid, bus.if_ready}), 128'(2'b00));
    end
    bus.if_valid = 1'b0;
    bus.if_req   = 1'b0;
    @(negedge clk);

    do_read(64'h0000_0000_0000_0004, 2'b10, 2, 1, 64'h7777_6666_5555_4444, 2'b01);

    repeat (2) @(negedge clk);
    check_eq("sb_empty", 128'(sb.size()), 128'(0));
    check_eq("pulse_count", 128'(pulses), 128'(n_reads));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
